// File: rtl/div_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB pair,
// with an A/M/Q register organisation shared with the shift-add multiplier.
module div_restoring #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SUB,
        DONE
    } state_t;

    state_t        state;
    logic [N:0]    a;
    logic [N:0]    m;
    logic [N:0]    diff;
    logic [N-1:0]  q;
    logic [CW-1:0] count;

    assign diff      = a - m;
    assign quotient  = q;
    assign remainder = a[N-1:0];

    // Controller and datapath; done defaults low so it can only pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a        <= '0;
            m        <= '0;
            q        <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            a        <= '0;
                            q        <= dividend;
                            m        <= {1'b0, divisor};
                            count    <= CW'(N);
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SHIFT;
                        end else begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            q        <= '1;
                            a        <= {1'b0, dividend};
                            div_zero <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    {a, q} <= {a[N-1:0], q, 1'b0};
                    state  <= SUB;
                end
                SUB: begin
                    if (!diff[N]) begin
                        a    <= diff;
                        q[0] <= 1'b1;
                    end
                    count <= count - CW'(1);
                    state <= (count == CW'(1)) ? DONE : SHIFT;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring.sv
// Scoreboard bench for div_restoring: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_div_restoring;

    localparam int unsigned N = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    typedef struct {
        int q;
        int r;
        int dz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    div_restoring #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("quotient", int'(quotient), e.q);
                check("remainder", int'(remainder), e.r);
                check("div_zero", int'(div_zero), e.dz);
            end
        end
    end

    // Hand-computed vector: issue a one-cycle start and queue its expected result.
    task automatic issue(input int dd, input int dv, input int eq, input int er);
        exp_t e;
        int   e0;
        @(negedge clk);
        dividend = N'(dd);
        divisor  = N'(dv);
        start    = 1'b1;
        e0       = cyc + 1;
        e.q      = eq;
        e.r      = er;
        e.dz     = (dv == 0) ? 1 : 0;
        e.cyc    = (dv == 0) ? e0 + 1 : e0 + 2 * N + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), (dv == 0) ? 0 : 1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("timeout_drain", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        @(negedge clk);
        reset = 1'b0;

        issue(7, 2, 3, 1);
        wait_drain();
        issue(6, 3, 2, 0);
        wait_drain();
        issue(2, 5, 0, 2);
        wait_drain();
        issue(7, 1, 7, 0);
        wait_drain();

        // Divide by zero: busy must stay low through the done pulse.
        issue(5, 0, 7, 5);
        check("dz_busy_done_cycle", int'(busy), 0);
        wait_drain();

        // Start pulsed mid-operation must be ignored.
        issue(7, 3, 2, 1);
        dividend = 3'd1;
        divisor  = 3'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("held_quotient", int'(quotient), 2);
        check("held_remainder", int'(remainder), 1);
        check("held_done", int'(done), 0);
        check("held_busy", int'(busy), 0);

        // Asynchronous reset mid-operation.
        issue(6, 4, 1, 2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_div_zero", int'(div_zero), 0);
        check("arst_quotient", int'(quotient), 0);
        check("arst_remainder", int'(remainder), 0);
        @(negedge clk);
        reset = 1'b0;
        issue(6, 4, 1, 2);
        wait_drain();

        // Back-to-back sweep with start held: one accept every 8 edges.
        for (int dd = 0; dd < 8; dd++) begin
            for (int dv = 1; dv < 8; dv++) begin
                exp_t e;
                dividend = N'(dd);
                divisor  = N'(dv);
                start    = 1'b1;
                e.q      = dd / dv;
                e.r      = dd % dv;
                e.dz     = 0;
                e.cyc    = cyc + 1 + 2 * N + 1;
                sb.push_back(e);
                repeat (8) @(negedge clk);
            end
        end
        start = 1'b0;
        wait_drain();
        check("final_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
